// File: rtl/cva6_tlb_sv32_core.sv
// Fully associative Sv32 TLB: zero-latency lookup, tree pseudo-LRU replacement,
// ASID/vaddr selective flush and raw state export.
module cva6_tlb_sv32_core #(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [62:0]               update_i,
  input  logic                      lu_access_i,
  input  logic [ASID_WIDTH-1:0]     lu_asid_i,
  input  logic [31:0]               lu_vaddr_i,
  input  logic [ASID_WIDTH-1:0]     asid_to_be_flushed_i,
  input  logic [31:0]               vaddr_to_be_flushed_i,
  output logic [31:0]               lu_content_o,
  output logic                      lu_is_4M_o,
  output logic                      lu_hit_o,
  output logic [31*TLB_ENTRIES-1:0] port_tags_q_o,
  output logic [32*TLB_ENTRIES-1:0] port_content_q_o
);

  localparam int unsigned IDX_W  = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam int unsigned TREE_W = TLB_ENTRIES - 1;

  typedef struct packed {
    logic [8:0] asid;
    logic [9:0] vpn1;
    logic [9:0] vpn0;
    logic       is_4m;
    logic       valid;
  } tag_t;

  tag_t              tags_q    [TLB_ENTRIES];
  tag_t              tags_d    [TLB_ENTRIES];
  logic [31:0]       content_q [TLB_ENTRIES];
  logic [31:0]       content_d [TLB_ENTRIES];
  logic [TREE_W-1:0] tree_q, tree_d;

  logic [TLB_ENTRIES-1:0] lu_match;
  logic [TLB_ENTRIES-1:0] fl_match;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       victim;
  logic [IDX_W:0]         vict_node;
  logic                   vict_dir;
  logic                   fl_asid_zero, fl_vaddr_zero, fl_vm, fl_am;

  logic unused_vaddr_bits;
  assign unused_vaddr_bits = ^lu_vaddr_i[11:0];

  // Mark an entry most-recently-used: every node on its path points to the other half.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                   input logic [IDX_W-1:0]  entry);
    logic [TREE_W-1:0] t;
    logic [IDX_W-1:0]  path;
    logic [IDX_W:0]    node;
    logic              dir;
    t    = tree;
    path = entry;
    node = '0;
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      dir                   = path[IDX_W-1];
      t[node[IDX_W-1:0]]    = ~dir;
      node                  = (node << 1) + (IDX_W+1)'(1) + (IDX_W+1)'(dir);
      path                  = path << 1;
    end
    return t;
  endfunction

  // Lookup: lowest-index matching entry drives the result.
  always_comb begin
    lu_match     = '0;
    hit_idx      = '0;
    lu_hit_o     = 1'b0;
    lu_content_o = '0;
    lu_is_4M_o   = 1'b0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      lu_match[i] = tags_q[i].valid
                  && (tags_q[i].vpn1 == lu_vaddr_i[31:22])
                  && (tags_q[i].is_4m || (tags_q[i].vpn0 == lu_vaddr_i[21:12]))
                  && ((tags_q[i].asid == 9'(lu_asid_i)) || content_q[i][5]);
    end
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (lu_match[i] && !lu_hit_o) begin
        lu_hit_o     = 1'b1;
        hit_idx      = IDX_W'(i);
        lu_content_o = content_q[i];
        lu_is_4M_o   = tags_q[i].is_4m;
      end
    end
  end

  // Flush selection: a zero selector acts as a wildcard; globals survive ASID flushes.
  always_comb begin
    fl_match      = '0;
    fl_vm         = 1'b0;
    fl_am         = 1'b0;
    fl_asid_zero  = (asid_to_be_flushed_i == '0);
    fl_vaddr_zero = (vaddr_to_be_flushed_i == '0);
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      fl_vm = (tags_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
            && (tags_q[i].is_4m || (tags_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]));
      fl_am = !content_q[i][5] && (tags_q[i].asid == 9'(asid_to_be_flushed_i));
      fl_match[i] = (fl_asid_zero || fl_am) && (fl_vaddr_zero || fl_vm);
    end
  end

  // Victim: follow the tree from the root, 0 = lower half, 1 = upper half.
  always_comb begin
    victim    = '0;
    vict_node = '0;
    vict_dir  = 1'b0;
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      vict_dir  = tree_q[vict_node[IDX_W-1:0]];
      victim    = (victim << 1) | IDX_W'(vict_dir);
      vict_node = (vict_node << 1) + (IDX_W+1)'(1) + (IDX_W+1)'(vict_dir);
    end
  end

  // Next state: flush wins over update; update's MRU marking is applied last.
  always_comb begin
    tags_d    = tags_q;
    content_d = content_q;
    tree_d    = tree_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        if (fl_match[i]) tags_d[i].valid = 1'b0;
      end
    end else begin
      if (lu_access_i && lu_hit_o) tree_d = plru_touch(tree_d, hit_idx);
      if (update_i[62]) begin
        tags_d[victim].asid  = update_i[40:32];
        tags_d[victim].vpn1  = update_i[60:51];
        tags_d[victim].vpn0  = update_i[50:41];
        tags_d[victim].is_4m = update_i[61];
        tags_d[victim].valid = 1'b1;
        content_d[victim]    = update_i[31:0];
        tree_d               = plru_touch(tree_d, victim);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        tags_q[i]    <= '0;
        content_q[i] <= '0;
      end
      tree_q <= '0;
    end else begin
      tags_q    <= tags_d;
      content_q <= content_d;
      tree_q    <= tree_d;
    end
  end

  for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_port
    assign port_tags_q_o[31*g +: 31]    = tags_q[g];
    assign port_content_q_o[32*g +: 32] = content_q[g];
  end

endmodule

// File: tb/tb_cva6_tlb_sv32_core.sv
// Bench for cva6_tlb_sv32_core: range-halving PLRU model checked every cycle,
// plus directed lookups with hand-computed results.
module tb_cva6_tlb_sv32_core;
  localparam int N = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          flush_i;
  logic [62:0]   update_i;
  logic          lu_access_i;
  logic [0:0]    lu_asid_i;
  logic [31:0]   lu_vaddr_i;
  logic [0:0]    asid_to_be_flushed_i;
  logic [31:0]   vaddr_to_be_flushed_i;
  logic [31:0]   lu_content_o;
  logic          lu_is_4M_o;
  logic          lu_hit_o;
  logic [31*N-1:0] port_tags_q_o;
  logic [32*N-1:0] port_content_q_o;

  cva6_tlb_sv32_core #(.TLB_ENTRIES(N), .ASID_WIDTH(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .update_i(update_i),
    .lu_access_i(lu_access_i), .lu_asid_i(lu_asid_i), .lu_vaddr_i(lu_vaddr_i),
    .asid_to_be_flushed_i(asid_to_be_flushed_i), .vaddr_to_be_flushed_i(vaddr_to_be_flushed_i),
    .lu_content_o(lu_content_o), .lu_is_4M_o(lu_is_4M_o), .lu_hit_o(lu_hit_o),
    .port_tags_q_o(port_tags_q_o), .port_content_q_o(port_content_q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [8:0]  m_asid [N];
  logic [9:0]  m_vpn1 [N];
  logic [9:0]  m_vpn0 [N];
  logic        m_4m   [N];
  logic        m_val  [N];
  logic [31:0] m_cont [N];
  logic        m_tree [N-1];

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_asid[i] = '0; m_vpn1[i] = '0; m_vpn0[i] = '0;
      m_4m[i] = 1'b0; m_val[i] = 1'b0; m_cont[i] = '0;
    end
    for (int i = 0; i < N-1; i++) m_tree[i] = 1'b0;
  endfunction

  function automatic int m_hit_idx();
    for (int i = 0; i < N; i++) begin
      if (m_val[i] && m_vpn1[i] == lu_vaddr_i[31:22]
          && (m_4m[i] || m_vpn0[i] == lu_vaddr_i[21:12])
          && (m_asid[i] == {8'd0, lu_asid_i} || m_cont[i][5]))
        return i;
    end
    return -1;
  endfunction

  // Tree nodes cover index ranges; a set node bit selects the upper half.
  function automatic int m_victim();
    int lo = 0, sz = N, node = 0;
    while (sz > 1) begin
      if (m_tree[node]) begin lo += sz / 2; node = 2 * node + 2; end
      else node = 2 * node + 1;
      sz = sz / 2;
    end
    return lo;
  endfunction

  function automatic void m_touch(input int e);
    int lo = 0, sz = N, node = 0;
    while (sz > 1) begin
      if (e < lo + sz / 2) begin m_tree[node] = 1'b1; node = 2 * node + 1; end
      else begin m_tree[node] = 1'b0; lo += sz / 2; node = 2 * node + 2; end
      sz = sz / 2;
    end
  endfunction

  function automatic void m_step();
    int  h, v;
    logic vm, am, sel;
    h = m_hit_idx();
    v = m_victim();
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        vm = m_vpn1[i] == vaddr_to_be_flushed_i[31:22]
             && (m_4m[i] || m_vpn0[i] == vaddr_to_be_flushed_i[21:12]);
        am = !m_cont[i][5] && m_asid[i] == {8'd0, asid_to_be_flushed_i};
        if (asid_to_be_flushed_i == 0 && vaddr_to_be_flushed_i == 0) sel = 1'b1;
        else if (asid_to_be_flushed_i == 0) sel = vm;
        else if (vaddr_to_be_flushed_i == 0) sel = am;
        else sel = vm && am;
        if (sel) m_val[i] = 1'b0;
      end
    end else begin
      if (lu_access_i && h >= 0) m_touch(h);
      if (update_i[62]) begin
        m_val[v]  = 1'b1;
        m_4m[v]   = update_i[61];
        m_vpn1[v] = update_i[60:51];
        m_vpn0[v] = update_i[50:41];
        m_asid[v] = update_i[40:32];
        m_cont[v] = update_i[31:0];
        m_touch(v);
      end
    end
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) m_clear();
    else m_step();
  end

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin : cmp
    int h;
    logic [127:0] tv, cv;
    h  = m_hit_idx();
    tv = '0;
    cv = '0;
    for (int i = 0; i < N; i++) begin
      tv[31*i +: 31] = {m_asid[i], m_vpn1[i], m_vpn0[i], m_4m[i], m_val[i]};
      cv[32*i +: 32] = m_cont[i];
    end
    chk("m_hit", 128'(lu_hit_o), 128'(h >= 0));
    if (h >= 0) begin
      chk("m_content", 128'(lu_content_o), 128'(m_cont[h]));
      chk("m_is4M", 128'(lu_is_4M_o), 128'(m_4m[h]));
    end else begin
      chk("m_content", 128'(lu_content_o), 128'(0));
      chk("m_is4M", 128'(lu_is_4M_o), 128'(0));
    end
    chk("m_tags", 128'(port_tags_q_o), tv);
    chk("m_cont_q", 128'(port_content_q_o), cv);
  end

  task automatic do_reset();
    @(posedge clk_i); #2 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_hit", 128'(lu_hit_o), 128'(0));
    chk("rst_tags", 128'(port_tags_q_o), 128'(0));
    chk("rst_cont", 128'(port_content_q_o), 128'(0));
    @(posedge clk_i); #2 rst_ni = 1'b1;
  endtask

  task automatic do_update(input logic is4m, input logic [19:0] vpn, input logic [8:0] asid,
                           input logic [31:0] c);
    update_i = {1'b1, is4m, vpn, asid, c};
    @(posedge clk_i); #1 update_i = '0;
  endtask

  task automatic do_flush(input logic a, input logic [31:0] va);
    asid_to_be_flushed_i = a; vaddr_to_be_flushed_i = va; flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
  endtask

  task automatic lookup(input string name, input logic [31:0] va, input logic a, input logic acc,
                        input logic eh, input logic [31:0] ec, input logic e4);
    lu_vaddr_i = va; lu_asid_i = a; lu_access_i = acc;
    @(negedge clk_i);
    chk({name, "_hit"}, 128'(lu_hit_o), 128'(eh));
    chk({name, "_content"}, 128'(lu_content_o), 128'(ec));
    chk({name, "_is4M"}, 128'(lu_is_4M_o), 128'(e4));
    @(posedge clk_i); #1 lu_access_i = 1'b0;
  endtask

  initial begin
    m_clear();
    rst_ni = 1'b1; flush_i = 1'b0; update_i = '0; lu_access_i = 1'b0; lu_asid_i = '0;
    lu_vaddr_i = '0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
    do_reset();

    // Basic write and ASID / global matching
    do_update(1'b0, 20'h12345, 9'd1, 32'hDEADB00F);
    @(negedge clk_i);
    chk("e0_content", 128'(port_content_q_o[31:0]), 128'(32'hDEADB00F));
    chk("e0_tag", 128'(port_tags_q_o[30:0]), 128'({9'd1, 10'h048, 10'h345, 1'b0, 1'b1}));
    @(posedge clk_i); #1;
    lookup("l_exact", 32'h12345000, 1'b1, 1'b0, 1'b1, 32'hDEADB00F, 1'b0);
    lookup("l_offset", 32'h12345FFC, 1'b1, 1'b0, 1'b1, 32'hDEADB00F, 1'b0);
    lookup("l_vpn0_miss", 32'h12346000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("l_asid_miss", 32'h12345000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_update(1'b0, 20'h12345, 9'd1, 32'hDEADB02F);
    lookup("l_global", 32'h12345000, 1'b0, 1'b0, 1'b1, 32'hDEADB02F, 1'b0);
    chk("global_in_e2", 128'(port_content_q_o[95:64]), 128'(32'hDEADB02F));

    // PLRU fill order and replacement after a touch
    do_reset();
    for (int k = 1; k <= 4; k++) do_update(1'b0, 20'(k), 9'd1, 32'h1000_0000 | 32'(k));
    @(negedge clk_i);
    chk("fill_order", 128'(port_content_q_o),
        {32'h1000_0004, 32'h1000_0002, 32'h1000_0003, 32'h1000_0001});
    @(posedge clk_i); #1;
    lookup("l_touch", 32'h00001000, 1'b1, 1'b1, 1'b1, 32'h1000_0001, 1'b0);
    do_update(1'b0, 20'h00005, 9'd1, 32'h1000_0005);
    @(negedge clk_i);
    chk("repl_e2_content", 128'(port_content_q_o[95:64]), 128'(32'h1000_0005));
    chk("repl_e2_vpn", 128'(port_tags_q_o[64 +: 20]), 128'(20'h00005));
    @(posedge clk_i); #1;
    lookup("l_vpn3_kept", 32'h00003000, 1'b1, 1'b0, 1'b1, 32'h1000_0003, 1'b0);

    // Superpage
    do_update(1'b1, {10'h048, 10'h3AB}, 9'd1, 32'hCAFE0001);
    lookup("l_4M_lo", 32'h12000000, 1'b1, 1'b0, 1'b1, 32'hCAFE0001, 1'b1);
    lookup("l_4M_hi", 32'h123FF000, 1'b1, 1'b0, 1'b1, 32'hCAFE0001, 1'b1);
    lookup("l_4M_out", 32'h12400000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("l_4M_asid", 32'h12000000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Flush everything: valid bits drop, data retained
    do_flush(1'b0, 32'h0);
    @(negedge clk_i);
    for (int i = 0; i < N; i++) chk($sformatf("flush_v%0d", i), 128'(port_tags_q_o[31*i]), 128'(0));
    chk("flush_keep", 128'(port_content_q_o[31:0]), 128'(32'h1000_0001));
    @(posedge clk_i); #1;
    lookup("l_fl_4M", 32'h12000000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("l_fl_vpn1", 32'h00001000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Selective flushes
    do_update(1'b0, 20'h00010, 9'd1, 32'h0000_0001);
    do_update(1'b0, 20'h00011, 9'd0, 32'h0000_0002);
    do_update(1'b0, 20'h00012, 9'd1, 32'h0000_0020);
    do_flush(1'b1, 32'h0);
    lookup("l_fa_gone", 32'h00010000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("l_fa_glob", 32'h00012000, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    lookup("l_fa_other", 32'h00011000, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
    do_flush(1'b0, 32'h00011000);
    lookup("l_fv_gone", 32'h00011000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("l_fv_keep", 32'h00012000, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    do_flush(1'b1, 32'h00012000);
    lookup("l_fb_glob", 32'h00012000, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0);

    // Flush beats a simultaneous update
    update_i = {1'b1, 1'b0, 20'h00077, 9'd1, 32'h77};
    do_flush(1'b1, 32'h00099000);
    update_i = '0;
    lookup("l_fl_upd", 32'h00077000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset mid-operation
    lu_vaddr_i = 32'h00012000; lu_asid_i = 1'b0;
    update_i = {1'b1, 1'b0, 20'h00055, 9'd1, 32'h55};
    @(posedge clk_i); #3 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_hit", 128'(lu_hit_o), 128'(0));
    chk("mid_rst_tags", 128'(port_tags_q_o), 128'(0));
    chk("mid_rst_cont", 128'(port_content_q_o), 128'(0));
    update_i = '0;
    @(posedge clk_i); #2 rst_ni = 1'b1;
    do_update(1'b0, 20'h12345, 9'd1, 32'hDEADB00F);
    lookup("l_after_rst", 32'h12345000, 1'b1, 1'b0, 1'b1, 32'hDEADB00F, 1'b0);

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cva6_tlb_sv32_core.md
CVA6_TLB_SV32_CORE -- requirements
Module: cva6_tlb_sv32

Interface
REQ-001 Parameter TLB_ENTRIES, default 4: number of fully associative entries (power of two, at least 2).
REQ-002 Parameter ASID_WIDTH, default 1: width of lookup and flush ASID inputs.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  flush request, one cycle.
REQ-006 update_i  input  63  update bundle: [62] valid, [61] is_4M, [60:51] vpn1, [50:41] vpn0, [40:32] asid (9 bits), [31:0] content (Sv32 PTE).
REQ-007 lu_access_i  input  1  lookup qualifier; a hit with this high updates replacement state.
REQ-008 lu_asid_i  input  ASID_WIDTH  lookup ASID.
REQ-009 lu_vaddr_i  input  32  lookup virtual address; vpn1=[31:22], vpn0=[21:12].
REQ-010 asid_to_be_flushed_i  input  ASID_WIDTH  flush ASID selector.
REQ-011 vaddr_to_be_flushed_i  input  32  flush virtual address selector.
REQ-012 lu_content_o  output  32  PTE of the hitting entry.
REQ-013 lu_is_4M_o  output  1  hitting entry is a 4 MiB superpage.
REQ-014 lu_hit_o  output  1  lookup hit.
REQ-015 port_tags_q_o  output  31*TLB_ENTRIES  raw tag state; entry i at [31i+30:31i] = {asid[8:0], vpn1[9:0], vpn0[9:0], is_4M, valid} (valid = bit 31i).
REQ-016 port_content_q_o  output  32*TLB_ENTRIES  raw content state; entry i at [32i+31:32i].

Function
REQ-017 Lookup SHALL be purely combinational from inputs and current state (zero latency).
REQ-018 Entry i SHALL match when valid AND vpn1 equal AND (is_4M OR vpn0 equal) AND (tag asid equals lu_asid_i zero-extended to 9 bits OR content bit 5, global, set).
REQ-019 lu_hit_o SHALL be 1 if any entry matches; lu_content_o/lu_is_4M_o SHALL come from the lowest-index match, else 0.
REQ-020 Replacement SHALL be tree pseudo-LRU (TLB_ENTRIES-1 bits); victim = leaf the tree points to; all-zero tree points to entry 0.
REQ-021 On lu_access_i and lu_hit_o, the tree SHALL be updated next edge so the hitting entry is most-recently-used (path bits point away).
REQ-022 When update_i[62]=1 and flush_i=0, the victim entry SHALL be written next edge: tag fields from update_i, valid=1, content=update_i[31:0]; the written entry SHALL become most-recently-used.
REQ-023 update_i[62]=0 SHALL leave tags and content unchanged.
REQ-024 flush_i=1 SHALL clear valid bits next edge (tag/content data retained): asid=0 and vaddr=0 -> all entries; asid=0, vaddr!=0 -> entries matching vaddr (vpn1, and vpn0 unless is_4M); asid!=0, vaddr=0 -> non-global entries whose asid equals asid_to_be_flushed_i; both nonzero -> non-global entries matching both.
REQ-025 flush_i SHALL take priority over a simultaneous update (update dropped); the replacement tree SHALL not change during a flush cycle.
REQ-026 Simultaneous lookup-hit-with-access and update: update's MRU marking SHALL win.
REQ-027 Port outputs SHALL reflect registered state directly, no extra latency.
REQ-028 Next state SHALL be a pure function of current state and inputs (no hidden state beyond tags, content, tree).

Reset
REQ-029 While rst_ni=0, all tag bits, content bits and tree bits SHALL be 0; lu_hit_o=0, lu_content_o=0, lu_is_4M_o=0, port outputs all 0.
REQ-030 Reset asserted mid-operation SHALL clear state immediately regardless of flush/update.

Verification
REQ-031 Reset, then update {valid,vpn=0x12345,asid=1,content=0xDEADB00F} -> entry 0 valid; lookup vaddr 0x12345000 asid 1 -> hit=1, content=0xDEADB00F.
REQ-032 Same entry, lookup asid 0 with content bit5=0 -> hit=0; rewrite with content bit5=1 -> hit=1.
REQ-033 Four updates vpn 1,2,3,4 -> entries 0..3 filled; lookup vpn 1 with lu_access_i=1; fifth update vpn 5 -> replaces entry other than 0 (entry 2 for tree order).
REQ-034 Update with is_4M=1, vpn1=0x048 -> lookup vaddr 0x12000000..0x123FF000 hits, lu_is_4M_o=1.
REQ-035 flush_i with asid 0, vaddr 0 -> all valid bits 0, other tag/content bits unchanged; subsequent lookups miss.
REQ-036 flush_i and update same cycle -> no entry written; reset asserted mid-sequence -> all ports 0.
